conv3x3_relu_pool2_engine: RTL and testbench
============================================

// Module: conv3x3_relu_pool2_engine
// PURPOSE
//  Streaming single-channel CNN stage: 3x3 valid conv (runtime-loadable weights) -> requant/saturate -> ReLU
//  -> 2x2/stride-2 max-pool. Successor to fixed-kernel conv/ReLU/pool pipeline: parametrised widths and
//  max line length, runtime frame size, valid/ready backpressure, frame control FSM. Sits between pixel source and feature sink.
// PARAMETERS
//  DATA_W  8    signed pixel/weight/output width
//  ACC_W   20   signed accumulator width (>= 2*DATA_W+4)
//  MAX_W   64   max img_width supported (line-buffer depth)
//  SHIFT   0    arithmetic right shift applied to conv sum before saturation
// PORTS
//  clk        in   1       clock, all logic rising-edge
//  rst_n      in   1       synchronous reset, active-low
//  start      in   1       pulse: latch img_width/img_height, begin frame
//  img_width  in   8       frame width, legal 3..MAX_W
//  img_height in   8       frame height, legal >=3
//  wgt_we     in   1       weight write strobe
//  wgt_addr   in   4       weight index 0..8, raster order (0=top-left)
//  wgt_data   in   DATA_W  signed weight
//  in_valid   in   1       pixel valid
//  in_ready   out  1       pixel accepted when in_valid&in_ready
//  pixel_in   in   DATA_W  signed pixel, raster order
//  out_valid  out  1       pooled result valid
//  out_ready  in   1       sink ready
//  dout       out  DATA_W  pooled result (>=0)
//  busy       out  1       frame in progress
//  frame_done out  1       1-cycle pulse after last output accepted
//  cfg_err    out  1       1-cycle pulse on rejected start
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters/line buffers/pool buffer cleared, weights=0 (bias=0).
//  FSM: IDLE -start&legal-> RUN (busy=1). RUN -last pixel accepted-> DRAIN. DRAIN -last output accepted-> IDLE, frame_done=1.
//   start with illegal size (w<3, w>MAX_W, h<3) in IDLE: stay IDLE, cfg_err=1. start in RUN/DRAIN ignored.
//  in_ready = (state==RUN) & adv, adv = out_ready | ~out_valid. Whole pipeline stalls when adv=0; no data lost/duplicated.
//  Window: pixel (r,c) completes window when r>=2,c>=2; conv map is (W-2)x(H-2). Windows never span rows.
//  Conv: sum_k w[k]*p[k] in ACC_W signed, registered (stage 1). Stage 2: >>>SHIFT, saturate to
//   [-2^(DATA_W-1), 2^(DATA_W-1)-1], ReLU (neg->0). Stage 3: pool.
//  Pool: conv coord (i,j); even-i rows store max of cols (j,j+1) pairs in MAX_W/2 buffer; odd-i row merges
//   -> output at odd i, odd j. Odd trailing conv row/col dropped. Outputs = floor((W-2)/2)*floor((H-2)/2).
//  Latency: 3 adv-cycles from acceptance of pixel completing a pool window to out_valid.
//  out_valid holds, dout stable, until out_ready. Zero-output frame (W or H in 3..4 odd case
//   e.g. W=3) -> DRAIN exits after pipeline empties, frame_done still pulses.
//  Weight writes: accepted only in IDLE; ignored in RUN/DRAIN. wgt_addr>8 ignored.
//  Reset asserted mid-frame: abandon frame, return to reset state on that edge; no frame_done.
//  start and last output same cycle in DRAIN: start ignored.
// CONFIGURATION
//  CONV_BIAS_EN defined: wgt_addr==9 writes signed DATA_W bias, sign-extended and added to conv sum before shift.
//  CONV_BIAS_EN undefined: no bias register; wgt_addr 9..15 ignored; sum is pure MAC.
// STRUCTURE
//  Package cnn_pkg: DATA_W/ACC_W defaults, state enum {IDLE,RUN,DRAIN}, saturate/relu function, KERNEL_TAPS=9.
//  Sub-module line_buffer_3x3: two MAX_W-deep row buffers + 3x3 shift window, clocked by adv&accept,
//   runtime width, emits win_valid. Engine holds weights, MAC, requant, pool, FSM.
// TESTING
//  1) W=H=4, pixels 0..15, w[4]=1 else 0, SHIFT=0 -> single dout=10, then frame_done.
//  2) W=H=4, all pixels 127, all weights 127 -> sum 145161 saturates -> dout=127.
//  3) W=H=6 ramp, all weights -1 -> 4 outputs all 0 (ReLU).
//  4) W=H=6, w[4]=1, out_ready toggling 1010.. and random in_valid -> dout 14,16,26,28 in order, none lost.
//  5) W=H=5 ramp, w[4]=1 -> 1 output dout=12; trailing conv row/col dropped.
//  6) start W=2 -> cfg_err pulse, busy=0; wgt_we during RUN -> weight unchanged in next frame; rst_n low mid-frame -> all outputs 0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the 3x3 conv / ReLU / 2x2 max-pool engine.
package cnn_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int ACC_W_DEF   = 20;
    localparam int KERNEL_TAPS = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Clamp to the positive signed range of dw bits; negatives go to zero (ReLU),
    // so the low saturation bound never matters.
    function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v, input int dw);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        if (v < 64'sd0) return '0;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/line_buffer_3x3.sv
// Two row buffers plus a 3x3 sliding window over a raster pixel stream of runtime width.
module line_buffer_3x3
    import cnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int MAX_W  = 64
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clear,
    input  logic                                adv,
    input  logic                                accept,
    input  logic [7:0]                          img_width,
    input  logic signed [DATA_W-1:0]            pixel_in,
    output logic [7:0]                          row,
    output logic [7:0]                          col,
    output logic [KERNEL_TAPS-1:0][DATA_W-1:0]  win,
    output logic                                win_valid
);

    localparam int AW = $clog2(MAX_W);

    logic [MAX_W-1:0][DATA_W-1:0] lb0;
    logic [MAX_W-1:0][DATA_W-1:0] lb1;
    logic [AW-1:0]                ci;

    assign ci = col[AW-1:0];

    // lb1 holds row r-2 and lb0 row r-1 at the current column; win[0] is top-left.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lb0       <= '0;
            lb1       <= '0;
            win       <= '0;
            row       <= '0;
            col       <= '0;
            win_valid <= 1'b0;
        end else if (clear) begin
            row       <= '0;
            col       <= '0;
            win_valid <= 1'b0;
        end else if (adv) begin
            // Window only counts once two columns of the same row sit behind it.
            win_valid <= accept && (row >= 8'd2) && (col >= 8'd2);
            if (accept) begin
                lb1[ci] <= lb0[ci];
                lb0[ci] <= pixel_in;
                win[0]  <= win[1];
                win[1]  <= win[2];
                win[2]  <= lb1[ci];
                win[3]  <= win[4];
                win[4]  <= win[5];
                win[5]  <= lb0[ci];
                win[6]  <= win[7];
                win[7]  <= win[8];
                win[8]  <= pixel_in;
                if (col == img_width - 8'd1) begin
                    col <= '0;
                    row <= row + 8'd1;
                end else begin
                    col <= col + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/conv3x3_relu_pool2_engine.sv
// Streaming 3x3 conv -> requant/saturate -> ReLU -> 2x2 max-pool with frame FSM.
// Optional CONV_BIAS_EN: weight address 9 loads a signed bias added to the conv sum.
module conv3x3_relu_pool2_engine
    import cnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int MAX_W  = 64,
    parameter int SHIFT  = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [7:0]                img_width,
    input  logic [7:0]                img_height,
    input  logic                      wgt_we,
    input  logic [3:0]                wgt_addr,
    input  logic signed [DATA_W-1:0]  wgt_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  pixel_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         dout,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      cfg_err
);

    localparam logic [8:0] MAX_W9 = 9'(MAX_W);
    localparam int         PD     = (MAX_W / 2 > 1) ? MAX_W / 2 : 2;
    localparam int         PW     = $clog2(PD);

    state_t state, state_nxt;
    logic [7:0] width_q, height_q;
    logic [KERNEL_TAPS-1:0][DATA_W-1:0] wgt;
`ifdef CONV_BIAS_EN
    logic signed [DATA_W-1:0] bias;
`endif

    logic adv, accept, size_ok, start_ok, last_pix, pipe_empty, drain_done;
    logic [7:0] row, col;
    logic [KERNEL_TAPS-1:0][DATA_W-1:0] win;
    logic win_valid;

    assign adv        = out_ready | ~out_valid;
    assign in_ready   = (state == RUN) & adv;
    assign accept     = in_valid & in_ready;
    assign busy       = (state != IDLE);
    assign size_ok    = (img_width >= 8'd3) && ({1'b0, img_width} <= MAX_W9) && (img_height >= 8'd3);
    assign start_ok   = start && (state == IDLE) && size_ok;
    assign last_pix   = accept && (row == height_q - 8'd1) && (col == width_q - 8'd1);

    line_buffer_3x3 #(
        .DATA_W (DATA_W),
        .MAX_W  (MAX_W)
    ) u_lb (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_ok),
        .adv       (adv),
        .accept    (accept),
        .img_width (width_q),
        .pixel_in  (pixel_in),
        .row       (row),
        .col       (col),
        .win       (win),
        .win_valid (win_valid)
    );

    // ---------------- stage 1: MAC ----------------
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    mac;
    logic signed [ACC_W-1:0]    acc_q;
    logic [1:0]                 vld_pipe;

    always_comb begin
        mac  = '0;
        prod = '0;
        for (int k = 0; k < KERNEL_TAPS; k++) begin
            prod = $signed(win[k]) * $signed(wgt[k]);
            mac  = mac + ACC_W'(prod);
        end
`ifdef CONV_BIAS_EN
        mac = mac + ACC_W'(bias);
`endif
    end

    // ---------------- stage 2: requant + ReLU ----------------
    logic signed [ACC_W-1:0] shifted;
    logic signed [63:0]      clipped;
    logic [DATA_W-1:0]       act;
    logic [DATA_W-1:0]       act_q;

    always_comb begin
        shifted = acc_q >>> SHIFT;
        clipped = sat_relu(64'(shifted), DATA_W);
        act     = clipped[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            acc_q    <= '0;
            act_q    <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[0], win_valid};
            acc_q    <= mac;
            act_q    <= act;
        end
    end

    // ---------------- stage 3: 2x2 max-pool ----------------
    logic [7:0]                 pi, pj, cw_last;
    logic [PD-1:0][DATA_W-1:0]  pbuf;
    logic [DATA_W-1:0]          pair_max, cmax_pair, out_max;
    logic [PW-1:0]              pidx;

    // Activations are non-negative after ReLU, so unsigned compares are exact.
    assign cw_last   = width_q - 8'd3;
    assign pidx      = pj[PW:1];
    assign cmax_pair = (act_q > pair_max) ? act_q : pair_max;
    assign out_max   = (pbuf[pidx] > cmax_pair) ? pbuf[pidx] : cmax_pair;

    // Even conv rows park column-pair maxima; odd rows merge and emit on odd columns.
    // A trailing odd row or column never reaches an emitting position.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pi        <= '0;
            pj        <= '0;
            pbuf      <= '0;
            pair_max  <= '0;
            out_valid <= 1'b0;
            dout      <= '0;
        end else if (start_ok) begin
            pi <= '0;
            pj <= '0;
        end else if (adv) begin
            out_valid <= vld_pipe[1] & pi[0] & pj[0];
            if (vld_pipe[1]) begin
                if (!pj[0])
                    pair_max <= act_q;
                else if (!pi[0])
                    pbuf[pidx] <= cmax_pair;
                else
                    dout <= out_max;
                if (pj == cw_last) begin
                    pj <= '0;
                    pi <= pi + 8'd1;
                end else begin
                    pj <= pj + 8'd1;
                end
            end
        end
    end

    // ---------------- frame control ----------------
    assign pipe_empty = ~win_valid & ~(|vld_pipe);
    assign drain_done = pipe_empty & (~out_valid | out_ready);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_ok)   state_nxt = RUN;
            RUN:     if (last_pix)   state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            width_q    <= '0;
            height_q   <= '0;
            wgt        <= '0;
`ifdef CONV_BIAS_EN
            bias       <= '0;
`endif
        end else begin
            state      <= state_nxt;
            frame_done <= (state == DRAIN) && drain_done;
            cfg_err    <= start && (state == IDLE) && !size_ok;
            if (start_ok) begin
                width_q  <= img_width;
                height_q <= img_height;
            end
            if (wgt_we && (state == IDLE)) begin
                if (wgt_addr < 4'd9)
                    wgt[wgt_addr] <= wgt_data;
`ifdef CONV_BIAS_EN
                else if (wgt_addr == 4'd9)
                    bias <= wgt_data;
`endif
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_relu_pool2_engine.sv
// Randomized/directed bench for conv3x3_relu_pool2_engine against a plain-arithmetic frame model.
module tb_conv3x3_relu_pool2_engine;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 20;
    localparam int MAX_W  = 64;
    localparam int SHIFT  = 0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        img_width = '0;
    logic [7:0]        img_height = '0;
    logic              wgt_we = 1'b0;
    logic [3:0]        wgt_addr = '0;
    logic signed [7:0] wgt_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [7:0] pixel_in = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [7:0]        dout;
    logic              busy, frame_done, cfg_err;

    int n_checks = 0;
    int n_fail   = 0;
    int wt[9];
    int pix[4096];

    always #5 clk = ~clk;

    conv3x3_relu_pool2_engine #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .MAX_W  (MAX_W),
        .SHIFT  (SHIFT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .img_width  (img_width),
        .img_height (img_height),
        .wgt_we     (wgt_we),
        .wgt_addr   (wgt_addr),
        .wgt_data   (wgt_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pixel_in   (pixel_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dout       (dout),
        .busy       (busy),
        .frame_done (frame_done),
        .cfg_err    (cfg_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_w(input int k, input int v);
        @(negedge clk);
        wgt_we   = 1'b1;
        wgt_addr = k[3:0];
        wgt_data = v[7:0];
        @(negedge clk);
        wgt_we = 1'b0;
        if (k < 9) wt[k] = v;
    endtask

    task automatic load_all(input int center, input int other);
        for (int k = 0; k < 9; k++) load_w(k, (k == 4) ? center : other);
    endtask

    // Conv value at map position (i,j) after shift, clip to 127 and ReLU.
    function automatic int conv_at(input int w, input int i, input int j);
        int s = 0;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
                s += wt[a*3+b] * pix[(i+a)*w + j + b];
        s = s >>> SHIFT;
        if (s > 127) s = 127;
        if (s < 0) s = 0;
        return s;
    endfunction

    task automatic run_frame(input string tag, input int w, input int h,
                             input int vmode, input int rmode, input bit poke);
        int expq[$];
        int got = 0;
        int fed = 0;
        int dones = 0;
        int n = w * h;
        for (int pi = 0; pi < (h-2)/2; pi++)
            for (int pj = 0; pj < (w-2)/2; pj++) begin
                int m = 0;
                for (int a = 0; a < 2; a++)
                    for (int b = 0; b < 2; b++)
                        if (conv_at(w, 2*pi+a, 2*pj+b) > m) m = conv_at(w, 2*pi+a, 2*pj+b);
                expq.push_back(m);
            end
        @(negedge clk);
        img_width  = w[7:0];
        img_height = h[7:0];
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check({tag, "_busy"}, busy, 1);
        if (poke) begin
            wgt_we   = 1'b1;
            wgt_addr = 4'd4;
            wgt_data = 8'sd99;
            @(negedge clk);
            wgt_we = 1'b0;
        end
        fork
            begin : feed
                int cyc = 0;
                while (fed < n && cyc < 4000) begin
                    @(negedge clk);
                    cyc++;
                    in_valid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
                    pixel_in = pix[fed][7:0];
                    #1;
                    if (in_valid && in_ready) fed++;
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin : sink
                int cyc = 0;
                logic held = 1'b0;
                logic [7:0] held_d = '0;
                while ((got < expq.size() || dones == 0) && cyc < 6000) begin
                    @(negedge clk);
                    cyc++;
                    out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
                    #1;
                    if (held) begin
                        check({tag, "_hold_valid"}, out_valid, 1);
                        check({tag, "_hold_dout"}, dout, held_d);
                    end
                    if (frame_done) dones++;
                    if (out_valid && out_ready) begin
                        if (got < expq.size()) check({tag, "_dout"}, dout, expq[got]);
                        else check({tag, "_extra_out"}, got + 1, expq.size());
                        got++;
                    end
                    held   = out_valid && !out_ready;
                    held_d = dout;
                end
                out_ready = 1'b1;
            end
        join
        check({tag, "_fed"}, fed, n);
        check({tag, "_count"}, got, expq.size());
        check({tag, "_done"}, dones, 1);
        @(negedge clk);
        #1;
        check({tag, "_idle"}, busy, 0);
        check({tag, "_done_pulse"}, frame_done, 0);
    endtask

    initial begin
        for (int k = 0; k < 9; k++) wt[k] = 0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_cfg_err", cfg_err, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // 1: 4x4 ramp, identity kernel
        load_all(1, 0);
        for (int k = 0; k < 16; k++) pix[k] = k;
        run_frame("t1", 4, 4, 0, 0, 1'b0);

        // 2: saturation
        load_all(127, 127);
        for (int k = 0; k < 16; k++) pix[k] = 127;
        run_frame("t2", 4, 4, 1, 2, 1'b0);

        // 3: all-negative kernel, ReLU zeroes everything
        load_all(-1, -1);
        for (int k = 0; k < 36; k++) pix[k] = k;
        run_frame("t3", 6, 6, 0, 0, 1'b0);

        // 4: backpressure with toggling sink and bursty source
        load_all(1, 0);
        run_frame("t4", 6, 6, 1, 1, 1'b0);

        // 5: odd map, trailing row/col dropped
        for (int k = 0; k < 25; k++) pix[k] = k;
        run_frame("t5", 5, 5, 0, 0, 1'b0);

        // Zero-output frame still completes
        for (int k = 0; k < 15; k++) pix[k] = k;
        run_frame("zero", 3, 5, 1, 2, 1'b0);

        // 6a: illegal sizes
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            img_width  = (t == 0) ? 8'd2 : (t == 1) ? 8'd5 : 8'd65;
            img_height = (t == 1) ? 8'd2 : 8'd5;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            #1;
            check("cfg_err_pulse", cfg_err, 1);
            check("cfg_err_busy", busy, 0);
            @(negedge clk);
            #1;
            check("cfg_err_clear", cfg_err, 0);
        end

        // 6b: write to an out-of-range address in IDLE and a weight write during RUN are ignored
        load_w(12, 50);
        for (int k = 0; k < 36; k++) pix[k] = k;
        run_frame("wgt_run", 6, 6, 0, 0, 1'b1);
        run_frame("wgt_next", 6, 6, 0, 0, 1'b0);

        // 6c: reset mid-frame
        @(negedge clk);
        img_width  = 8'd6;
        img_height = 8'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 28; k++) begin
            in_valid = 1'b1;
            pixel_in = k[7:0];
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_dout", dout, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_frame_done", frame_done, 0);
        check("mid_rst_cfg_err", cfg_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) wt[k] = 0;

        // Weights cleared by reset
        for (int k = 0; k < 16; k++) pix[k] = k + 20;
        run_frame("post_rst", 4, 4, 0, 0, 1'b0);

        // Randomized frames
        for (int r = 0; r < 5; r++) begin
            int w = int'($urandom_range(3, 12));
            int h = int'($urandom_range(3, 10));
            for (int k = 0; k < 9; k++) load_w(k, int'($urandom_range(0, 6)) - 3);
            for (int k = 0; k < w*h; k++) pix[k] = int'($urandom_range(0, 255)) - 128;
            run_frame("rand", w, h, 1, 2, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
